// File: rtl/trace_pkg.sv
// Shared trace types: the record carried by every trace source and the arbiter width limit.
package trace_pkg;

  typedef struct packed {
    logic [31:0] timestamp;
    logic [15:0] payload;
    logic [7:0]  tag;
  } trace_record_t;

  localparam int TRACE_ARB_MAX_SRC = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first requester at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  always_comb begin : pick
    int  j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j[W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trace_rr_arbiter.sv
// Merges NUM_SRC trace streams into one through a single registered slot,
// round-robin among enabled sources, with saturating grant/stall/wait statistics.
module trace_rr_arbiter
  import trace_pkg::*;
#(
  parameter int  NUM_SRC  = 4,
  localparam int SRC_ID_W = $clog2(NUM_SRC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  src_valid,
  output logic [NUM_SRC-1:0]  src_ready,
  input  trace_record_t       src_data [NUM_SRC],
  input  logic [NUM_SRC-1:0]  src_enable,
  output logic                out_valid,
  input  logic                out_ready,
  output trace_record_t       out_data,
  output logic [SRC_ID_W-1:0] out_src_id,
  output logic [63:0]         grant_count,
  output logic [63:0]         out_stall_cycles,
  output logic [31:0]         max_wait_cycles
);

  function automatic logic [63:0] sat_inc64(input logic [63:0] v);
    return (&v) ? v : v + 64'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic                out_valid_q, out_valid_d;
  trace_record_t       out_data_q, out_data_d;
  logic [SRC_ID_W-1:0] out_src_id_q, out_src_id_d;
  logic [SRC_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [63:0]         grant_q, grant_d;
  logic [63:0]         stall_q, stall_d;
  logic [31:0]         max_wait_q, max_wait_d;
  logic [31:0]         wait_q [NUM_SRC];
  logic [31:0]         wait_d [NUM_SRC];

  logic [NUM_SRC-1:0]  req;
  logic [NUM_SRC-1:0]  pick_gnt;
  logic [SRC_ID_W-1:0] pick_idx;
  logic                slot_free;
  logic                accept;

  assign req = src_valid & src_enable;

  rr_pick #(.N(NUM_SRC)) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Gating with rst_n keeps every src_ready low while reset is asserted.
  assign slot_free = !out_valid_q || out_ready;
  assign src_ready = (slot_free && rst_n) ? pick_gnt : '0;
  assign accept    = |src_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_id_d = out_src_id_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    stall_d      = stall_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = src_data[pick_idx];
      out_src_id_d = pick_idx;
      rr_ptr_d     = (int'(pick_idx) == NUM_SRC - 1) ? '0 : pick_idx + 1'b1;
      grant_d      = sat_inc64(grant_q);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (out_valid_q && !out_ready) stall_d = sat_inc64(stall_q);
  end

  // A source waits while it is eligible but not handed src_ready this cycle.
  always_comb begin
    max_wait_d = max_wait_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      wait_d[i] = (req[i] && !src_ready[i]) ? sat_inc32(wait_q[i]) : 32'd0;
      if (wait_d[i] > max_wait_d) max_wait_d = wait_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_id_q <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      stall_q      <= '0;
      max_wait_q   <= '0;
      for (int i = 0; i < NUM_SRC; i++) wait_q[i] <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_id_q <= out_src_id_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      stall_q      <= stall_d;
      max_wait_q   <= max_wait_d;
      for (int i = 0; i < NUM_SRC; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_src_id       = out_src_id_q;
  assign grant_count      = grant_q;
  assign out_stall_cycles = stall_q;
  assign max_wait_cycles  = max_wait_q;

endmodule

// File: doc/trace_rr_arbiter.md
TRACE_RR_ARBITER -- requirements
Module: trace_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of trace sources (2..16).
REQ-002 SHALL have localparam SRC_ID_W = $clog2(NUM_SRC), source index width.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port src_valid  input  NUM_SRC  per-source trace record valid.
REQ-006 SHALL have port src_ready  output  NUM_SRC  per-source accept.
REQ-007 SHALL have port src_data  input  NUM_SRC x trace_record_t  per-source trace record.
REQ-008 SHALL have port src_enable  input  NUM_SRC  per-source arbitration enable mask.
REQ-009 SHALL have port out_valid  output  1  merged record valid.
REQ-010 SHALL have port out_ready  input  1  sink accept.
REQ-011 SHALL have port out_data  output  trace_record_t  merged record.
REQ-012 SHALL have port out_src_id  output  SRC_ID_W  index of source that produced out_data.
REQ-013 SHALL have port grant_count  output  64  total records accepted from all sources.
REQ-014 SHALL have port out_stall_cycles  output  64  cycles with out_valid=1 and out_ready=0.
REQ-015 SHALL have port max_wait_cycles  output  32  longest observed per-source wait (valid and enabled but not ready).

Function
REQ-016 SHALL hold one registered output slot (out_valid/out_data/out_src_id); slot "free" = !out_valid | out_ready.
REQ-017 SHALL select, when slot free, the first source i with src_valid[i] & src_enable[i], searching from rr_ptr upward modulo NUM_SRC.
REQ-018 SHALL assert src_ready only for the selected source and only when slot free; at most one src_ready bit high per cycle (one-hot or zero).
REQ-019 SHALL load out_data/out_src_id with the accepted record and set out_valid on the clock edge after src_valid[i]&src_ready[i]; latency exactly 1 cycle.
REQ-020 SHALL clear out_valid after out_valid&out_ready when no source is accepted in the same cycle; accept+drain same cycle keeps out_valid=1 with new data (full throughput, 1 record/cycle).
REQ-021 SHALL keep out_data and out_src_id stable while out_valid=1 and out_ready=0.
REQ-022 SHALL set rr_ptr to (i+1) mod NUM_SRC on each accept from source i; rr_ptr unchanged otherwise.
REQ-023 SHALL never grant a source with src_enable=0; its pending record stays held by the source, never dropped or counted.
REQ-024 SHALL increment grant_count by 1 per accept; 64-bit saturating at all-ones.
REQ-025 SHALL increment out_stall_cycles per cycle out_valid=1 & out_ready=0; 64-bit saturating.
REQ-026 SHALL keep per-source 32-bit wait counters: increment while src_valid&src_enable&!src_ready, clear on accept or when valid/enable drops; max_wait_cycles = running max of all, saturating.
REQ-027 SHALL produce no output and leave all state except counters unchanged when no source is eligible.

Reset
REQ-028 SHALL, on rst_n low (async, any cycle incl. mid-transfer), force out_valid=0, src_ready=0, out_data=0, out_src_id=0, rr_ptr=0, all counters=0; held record is discarded.
REQ-029 SHALL take first accept no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-030 SHALL use trace_record_t from trace_pkg; package gains only TRACE_ARB_MAX_SRC=16 constant.
REQ-031 SHALL put the rotate-and-priority-pick in one sub-module rr_pick (combinational, inputs req mask and rr_ptr, output one-hot grant and index); the slot, pointer and counters stay in trace_rr_arbiter.

Verification
REQ-032 SHALL cover: NUM_SRC=4, all valid+enabled, out_ready=1 -> out_src_id sequence 0,1,2,3,0,1; grant_count=6 after 6 cycles.
REQ-033 SHALL cover: only src 2 valid, out_ready=0 for 5 cycles -> out_valid held, out_data stable, out_stall_cycles=5, src_ready[2]=0 during stall.
REQ-034 SHALL cover: src_enable=4'b1011, all valid -> src 2 never granted; sequence 0,1,3,0; src 2 record unchanged on its bus.
REQ-035 SHALL cover: src 0 and 3 valid, rr_ptr=1 -> grant 3 first then 0; at most one src_ready high every cycle.
REQ-036 SHALL cover: rst_n pulled low while out_valid=1 and out_ready=0 -> out_valid=0 immediately (async), counters 0, first post-reset grant from src 0.
REQ-037 SHALL cover: src 1 valid+enabled, blocked 7 cycles by out_ready=0 behind a held record -> max_wait_cycles=7 after its accept.
